// File: rtl/fib_random_decoder.sv
// Fibonacci-weighted codeword to binary decoder, fixed latency, one bit per cycle.
// Ports: clk, rst (sync, active-high), en_decode, fibonacci_random in;
//        input_binary_o, range_err_o, busy_o, convert_done out.
module fib_random_decoder #(
    parameter int N_BITS = 64,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_decode,
    input  logic [N_BITS-1:0] fibonacci_random,
    output logic [OUT_W-1:0]  input_binary_o,
    output logic              range_err_o,
    output logic              busy_o,
    output logic              convert_done
);

    localparam int CNT_W = $clog2(N_BITS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [N_BITS-1:0] sr;
    logic [ACC_W-1:0]  acc;
    // fa is the weight of the bit currently at sr[0]; fb is the next term.
    logic [ACC_W-1:0]  fa;
    logic [ACC_W-1:0]  fb;
    logic [CNT_W-1:0]  cnt;

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sr             <= '0;
            acc            <= '0;
            fa             <= '0;
            fb             <= '0;
            cnt            <= '0;
            input_binary_o <= '0;
            range_err_o    <= 1'b0;
            convert_done   <= 1'b0;
        end else begin
            convert_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en_decode) begin
                        sr    <= fibonacci_random;
                        acc   <= '0;
                        fa    <= ACC_W'(1);
                        fb    <= ACC_W'(2);
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (sr[0]) begin
                        acc <= acc + fa;
                    end
                    sr  <= sr >> 1;
                    fa  <= fb;
                    fb  <= fa + fb;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N_BITS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    input_binary_o <= acc[OUT_W-1:0];
                    range_err_o    <= |acc[ACC_W-1:OUT_W];
                    convert_done   <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_random_decoder.sv
// Self-checking bench for fib_random_decoder: directed cases plus random
// codewords checked against a Fibonacci-sum reference model.
module tb_fib_random_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_decode;
    logic [63:0] fibonacci_random;
    logic [15:0] input_binary_o;
    logic        range_err_o;
    logic        busy_o;
    logic        convert_done;

    int passed = 0;
    int total  = 0;

    fib_random_decoder dut (
        .clk              (clk),
        .rst              (rst),
        .en_decode        (en_decode),
        .fibonacci_random (fibonacci_random),
        .input_binary_o   (input_binary_o),
        .range_err_o      (range_err_o),
        .busy_o           (busy_o),
        .convert_done     (convert_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: sum of F(i+2) over set bits, with F(1)=F(2)=1.
    function automatic longint unsigned fib_sum(input logic [63:0] c);
        longint unsigned f [0:70];
        longint unsigned s;
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i <= 70; i++) f[i] = f[i-1] + f[i-2];
        s = 0;
        for (int i = 0; i < 64; i++) if (c[i]) s += f[i+2];
        return s;
    endfunction

    // Accept a request on the next edge, then count edges until done.
    task automatic run_conv(input logic [63:0] code, output int lat);
        en_decode        = 1'b1;
        fibonacci_random = code;
        tick();
        en_decode        = 1'b0;
        fibonacci_random = {$urandom, $urandom};
        lat = 0;
        while (!convert_done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic conv_check(input string tag, input logic [63:0] code,
                              input logic [15:0] exp_v, input logic exp_e);
        int lat;
        run_conv(code, lat);
        check({tag, "_lat"}, 64'(lat), 64'd65);
        check({tag, "_val"}, 64'(input_binary_o), 64'(exp_v));
        check({tag, "_err"}, 64'(range_err_o), 64'(exp_e));
    endtask

    task automatic model_check(input string tag, input logic [63:0] code);
        longint unsigned s;
        s = fib_sum(code);
        conv_check(tag, code, s[15:0], s >= 64'd65536);
    endtask

    initial begin
        int lat;
        int pulses;
        int first_k;
        logic [63:0] code;

        rst              = 1'b1;
        en_decode        = 1'b0;
        fibonacci_random = '0;
        tick();
        tick();
        check("rst_val",  64'(input_binary_o), 64'd0);
        check("rst_err",  64'(range_err_o),    64'd0);
        check("rst_done", 64'(convert_done),   64'd0);
        check("rst_busy", 64'(busy_o),         64'd0);
        rst = 1'b0;
        tick();

        conv_check("t1", 64'h1, 16'd1, 1'b0);
        tick();
        check("t1_pulse", 64'(convert_done), 64'd0);

        conv_check("t2_15", 64'h15, 16'd12, 1'b0);
        conv_check("t2_3",  64'h3,  16'd3,  1'b0);
        conv_check("t2_4",  64'h4,  16'd3,  1'b0);
        conv_check("t3_f24", 64'h1 << 22, 16'hB520, 1'b0);
        conv_check("t3_f25", 64'h1 << 23, 16'h2511, 1'b1);
        model_check("t4_ones", 64'hFFFF_FFFF_FFFF_FFFF);
        model_check("zero", 64'h0);
        model_check("msb", 64'h8000_0000_0000_0000);

        for (int i = 0; i < 8; i++) begin
            code = {$urandom, $urandom};
            if (i < 3) code = code & 64'h3F_FFFF;
            model_check($sformatf("rnd%0d", i), code);
        end

        // Re-requests while busy must be ignored.
        tick();
        en_decode        = 1'b1;
        fibonacci_random = 64'h15;
        tick();
        en_decode        = 1'b0;
        check("t5_busy", 64'(busy_o), 64'd1);
        pulses  = 0;
        first_k = 0;
        for (int k = 1; k <= 70; k++) begin
            en_decode        = (k == 10 || k == 64);
            fibonacci_random = 64'h1;
            tick();
            en_decode = 1'b0;
            if (convert_done) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (k == 65) break;
        end
        check("t5_first_k", 64'(first_k), 64'd65);
        check("t5_pulses",  64'(pulses),  64'd1);
        check("t5_val",     64'(input_binary_o), 64'd12);
        // Back-to-back: request during the done cycle.
        run_conv(64'h4, lat);
        check("t5_b2b_gap", 64'(lat + 1), 64'd66);
        check("t5_b2b_val", 64'(input_binary_o), 64'd3);

        // Reset mid-conversion aborts without a done pulse.
        tick();
        en_decode        = 1'b1;
        fibonacci_random = 64'hFFFF;
        tick();
        en_decode = 1'b0;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_val",  64'(input_binary_o), 64'd0);
        check("t6_err",  64'(range_err_o),    64'd0);
        check("t6_busy", 64'(busy_o),         64'd0);
        check("t6_done", 64'(convert_done),   64'd0);
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (convert_done) pulses++;
        end
        check("t6_nopulse", 64'(pulses), 64'd0);
        conv_check("t6_after", 64'h15, 16'd12, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
